// File: rtl/mips_ctrl_seq.sv
// Registered MIPS decode/control unit: ID decode into an ID/EX control register with
// hold/bubble, syscall handshake FSM toward the DMA with timeout, sticky halt, illegal flag.
module mips_ctrl_seq #(
   parameter int ALUOP_W     = 4,
   parameter int CNT_W       = 8,
   parameter int SYS_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   input  logic [5:0]         opcode,
   input  logic [5:0]         func,
   input  logic               ex_stall,
   input  logic               flush_in,
   input  logic               dma_ack,
   output logic               if_flush,
   output logic               ctrl_valid,
   output logic               reg_dest,
   output logic               mem_read,
   output logic               mem_to_reg,
   output logic               mem_write,
   output logic               alu_src,
   output logic               reg_write,
   output logic               branch,
   output logic               branch_not,
   output logic               jump,
   output logic               jump_r,
   output logic               jal,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               stall_out,
   output logic               dma_req,
   output logic               halted,
   output logic               illegal,
   output logic               sys_timeout
);

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_XORI  = 6'd14;
   localparam logic [5:0] OP_LUI   = 6'd15;
   localparam logic [5:0] OP_LB    = 6'd32;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_SYS   = 6'd62;
   localparam logic [5:0] OP_HALT  = 6'd63;
   localparam logic [5:0] FN_JR    = 6'd8;

   localparam bit         TO_EN    = (SYS_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(SYS_TIMEOUT - 1);

   typedef enum logic [1:0] {S_RUN, S_SYS_WAIT, S_HALT} state_t;

   typedef struct packed {
      logic               reg_dest;
      logic               mem_read;
      logic               mem_to_reg;
      logic               mem_write;
      logic               alu_src;
      logic               reg_write;
      logic               branch;
      logic               branch_not;
      logic               jump;
      logic               jump_r;
      logic               jal;
      logic [ALUOP_W-1:0] alu_op;
   } ctrl_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   ctrl_t              r_ctrl, w_dec;
   logic               r_valid;
   logic               r_illegal, r_sys_timeout;
   logic               w_is_sys, w_is_halt, w_is_ill;
   logic               w_accept, w_timeout;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      w_dec     = '0;
      w_is_sys  = 1'b0;
      w_is_halt = 1'b0;
      w_is_ill  = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            w_dec.reg_dest = 1'b1;
            if (func == FN_JR) w_dec.jump_r    = 1'b1;
            else               w_dec.reg_write = 1'b1;
         end
         OP_LW, OP_LB: begin
            w_dec.mem_read   = 1'b1;
            w_dec.mem_to_reg = 1'b1;
            w_dec.alu_src    = 1'b1;
            w_dec.reg_write  = 1'b1;
            w_dec.alu_op     = ALUOP_W'(2);
         end
         OP_SW: begin
            w_dec.mem_write = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.alu_op    = ALUOP_W'(2);
         end
         OP_BEQ: begin
            w_dec.branch = 1'b1;
            w_dec.alu_op = ALUOP_W'(6);
         end
         OP_BNE: begin
            w_dec.branch_not = 1'b1;
            w_dec.alu_op     = ALUOP_W'(6);
         end
         OP_J:   w_dec.jump = 1'b1;
         OP_JAL: begin
            w_dec.jal       = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.reg_dest  = 1'b1;
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: begin
            w_dec.alu_src   = 1'b1;
            w_dec.reg_write = 1'b1;
            case (opcode)
               OP_ADDI: w_dec.alu_op = ALUOP_W'(2);
               OP_ORI:  w_dec.alu_op = ALUOP_W'(1);
               OP_XORI: w_dec.alu_op = ALUOP_W'(13);
               OP_SLTI: w_dec.alu_op = ALUOP_W'(7);
               OP_LUI:  w_dec.alu_op = ALUOP_W'(14);
               default: w_dec.alu_op = ALUOP_W'(0);
            endcase
         end
         OP_SYS:  w_is_sys  = 1'b1;
         OP_HALT: w_is_halt = 1'b1;
         default: w_is_ill  = 1'b1;
      endcase
   end

   assign w_accept = (r_state == S_RUN) & instr_valid & ~ex_stall & ~flush_in;
   assign if_flush = instr_valid & (r_state == S_RUN) &
                     (w_dec.jump | w_dec.jump_r | w_dec.branch | w_dec.branch_not);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_timeout   = 1'b0;
      case (r_state)
         S_RUN: begin
            if (w_accept && w_is_sys) begin
               w_state_nxt = S_SYS_WAIT;
               w_cnt_nxt   = '0;
            end else if (w_accept && w_is_halt) begin
               w_state_nxt = S_HALT;
            end
         end
         S_SYS_WAIT: begin
            // An ack in the same cycle as the last timeout cycle completes the syscall normally.
            if (dma_ack) begin
               w_state_nxt = S_RUN;
            end else if (TO_EN && r_cnt == TO_LAST) begin
               w_state_nxt = S_RUN;
               w_timeout   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_RUN;
         r_cnt         <= '0;
         r_illegal     <= 1'b0;
         r_sys_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_illegal     <= w_accept & w_is_ill;
         r_sys_timeout <= w_timeout;
      end
   end

   // ID/EX: flush beats stall; anything not a normal accepted instruction becomes a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ctrl  <= '0;
         r_valid <= 1'b0;
      end else if (flush_in) begin
         r_ctrl  <= '0;
         r_valid <= 1'b0;
      end else if (!ex_stall) begin
         if (w_accept && !w_is_sys && !w_is_halt && !w_is_ill) begin
            r_ctrl  <= w_dec;
            r_valid <= 1'b1;
         end else begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
         end
      end
   end

   assign ctrl_valid  = r_valid;
   assign reg_dest    = r_ctrl.reg_dest;
   assign mem_read    = r_ctrl.mem_read;
   assign mem_to_reg  = r_ctrl.mem_to_reg;
   assign mem_write   = r_ctrl.mem_write;
   assign alu_src     = r_ctrl.alu_src;
   assign reg_write   = r_ctrl.reg_write;
   assign branch      = r_ctrl.branch;
   assign branch_not  = r_ctrl.branch_not;
   assign jump        = r_ctrl.jump;
   assign jump_r      = r_ctrl.jump_r;
   assign jal         = r_ctrl.jal;
   assign alu_op      = r_ctrl.alu_op;
   assign stall_out   = (r_state == S_SYS_WAIT) | (r_state == S_HALT);
   assign dma_req     = (r_state == S_SYS_WAIT);
   assign halted      = (r_state == S_HALT);
   assign illegal     = r_illegal;
   assign sys_timeout = r_sys_timeout;

endmodule

// File: tb/tb_mips_ctrl_seq.sv
// Self-checking bench for mips_ctrl_seq: decode table vectors, hand-written multi-cycle
// sequences and randomized stimulus against a cycle-level reference model.
module tb_mips_ctrl_seq;

   logic       clk = 1'b0;
   logic       rst, instr_valid, ex_stall, flush_in, dma_ack;
   logic [5:0] opcode, func;

   logic       if_flush, ctrl_valid, reg_dest, mem_read, mem_to_reg, mem_write, alu_src;
   logic       reg_write, branch, branch_not, jump, jump_r, jal;
   logic [3:0] alu_op;
   logic       stall_out, dma_req, halted, illegal, sys_timeout;

   logic       if_flush_b, ctrl_valid_b, reg_dest_b, mem_read_b, mem_to_reg_b, mem_write_b, alu_src_b;
   logic       reg_write_b, branch_b, branch_not_b, jump_b, jump_r_b, jal_b;
   logic [3:0] alu_op_b;
   logic       stall_out_b, dma_req_b, halted_b, illegal_b, sys_timeout_b;

   always #5 clk = ~clk;

   mips_ctrl_seq #(.ALUOP_W(4), .CNT_W(8), .SYS_TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .func(func),
      .ex_stall(ex_stall), .flush_in(flush_in), .dma_ack(dma_ack), .if_flush(if_flush),
      .ctrl_valid(ctrl_valid), .reg_dest(reg_dest), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
      .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write), .branch(branch),
      .branch_not(branch_not), .jump(jump), .jump_r(jump_r), .jal(jal), .alu_op(alu_op),
      .stall_out(stall_out), .dma_req(dma_req), .halted(halted), .illegal(illegal),
      .sys_timeout(sys_timeout));

   mips_ctrl_seq #(.ALUOP_W(4), .CNT_W(8), .SYS_TIMEOUT(4)) dut_t4 (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .func(func),
      .ex_stall(ex_stall), .flush_in(flush_in), .dma_ack(dma_ack), .if_flush(if_flush_b),
      .ctrl_valid(ctrl_valid_b), .reg_dest(reg_dest_b), .mem_read(mem_read_b),
      .mem_to_reg(mem_to_reg_b), .mem_write(mem_write_b), .alu_src(alu_src_b),
      .reg_write(reg_write_b), .branch(branch_b), .branch_not(branch_not_b), .jump(jump_b),
      .jump_r(jump_r_b), .jal(jal_b), .alu_op(alu_op_b), .stall_out(stall_out_b),
      .dma_req(dma_req_b), .halted(halted_b), .illegal(illegal_b), .sys_timeout(sys_timeout_b));

   // Output word: {ctrl_valid, 11 control bits, alu_op, stall_out, dma_req, halted, illegal, sys_timeout}
   logic [20:0] act_main, act_b, act;
   logic        ifl_act;
   bit          use_t4 = 1'b0;

   assign act_main = {ctrl_valid, reg_dest, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
                      branch, branch_not, jump, jump_r, jal, alu_op,
                      stall_out, dma_req, halted, illegal, sys_timeout};
   assign act_b    = {ctrl_valid_b, reg_dest_b, mem_read_b, mem_to_reg_b, mem_write_b, alu_src_b,
                      reg_write_b, branch_b, branch_not_b, jump_b, jump_r_b, jal_b, alu_op_b,
                      stall_out_b, dma_req_b, halted_b, illegal_b, sys_timeout_b};
   assign act      = use_t4 ? act_b : act_main;
   assign ifl_act  = use_t4 ? if_flush_b : if_flush;

   // ctrl field: {reg_dest, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
   //              branch, branch_not, jump, jump_r, jal, alu_op[3:0]}
   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [14:0] ctrl;
      logic        vld;
      logic        ifl;
      logic        ill;
   } vec_t;

   vec_t tbl[16];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference model state: mode 0 = running, 1 = waiting on DMA, 2 = halted.
   int          m_mode;
   int          m_waited;
   logic [14:0] m_ctrl;
   logic        m_valid, m_ill, m_to;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // kind: 0 normal, 1 syscall, 2 halt, 3 illegal. Decode values come from the vector table.
   function automatic void lookup(input logic [5:0] op, input logic [5:0] fn,
                                  output logic [14:0] c, output int kind);
      c    = '0;
      kind = 3;
      if (op == 6'd62)      kind = 1;
      else if (op == 6'd63) kind = 2;
      else
         for (int i = 0; i < 16; i++)
            if (!tbl[i].ill && tbl[i].op == op && (op != 6'd0 || ((fn == 6'd8) == (tbl[i].fn == 6'd8)))) begin
               c    = tbl[i].ctrl;
               kind = 0;
            end
   endfunction

   function automatic logic exp_ifl();
      return instr_valid && m_mode == 0 &&
             (opcode == 6'd2 || opcode == 6'd4 || opcode == 6'd5 || (opcode == 6'd0 && func == 6'd8));
   endfunction

   function automatic logic [20:0] exp_word();
      return {m_valid, m_ctrl, m_mode != 0, m_mode == 1, m_mode == 2, m_ill, m_to};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_waited = 0; m_ctrl = '0; m_valid = 1'b0; m_ill = 1'b0; m_to = 1'b0;
   endtask

   task automatic model_edge();
      logic [14:0] c;
      int          kind;
      bit          acc;
      int          limit;
      limit = use_t4 ? 4 : 255;
      lookup(opcode, func, c, kind);
      acc   = (m_mode == 0) && instr_valid && !ex_stall && !flush_in;
      m_ill = acc && kind == 3;
      m_to  = 1'b0;
      if (flush_in) begin
         m_valid = 1'b0; m_ctrl = '0;
      end else if (!ex_stall) begin
         if (acc && kind == 0) begin
            m_valid = 1'b1; m_ctrl = c;
         end else begin
            m_valid = 1'b0; m_ctrl = '0;
         end
      end
      if (m_mode == 0) begin
         if (acc && kind == 1) begin
            m_mode = 1; m_waited = 0;
         end else if (acc && kind == 2) m_mode = 2;
      end else if (m_mode == 1) begin
         m_waited++;
         if (dma_ack) m_mode = 0;
         else if (m_waited == limit) begin
            m_mode = 0; m_to = 1'b1;
         end
      end
   endtask

   // Starts and ends 1 time unit after a rising edge.
   task automatic step(input string tag, input logic iv, input logic [5:0] op, input logic [5:0] fn,
                       input logic st, input logic fl, input logic ack);
      instr_valid = iv; opcode = op; func = fn; ex_stall = st; flush_in = fl; dma_ack = ack;
      #1;
      check({tag, "_if_flush"}, 32'(ifl_act), 32'(exp_ifl()));
      @(posedge clk);
      model_edge();
      #1;
      check({tag, "_outs"}, 32'(act), 32'(exp_word()));
   endtask

   task automatic do_reset();
      rst = 1'b1; instr_valid = 1'b0; ex_stall = 1'b0; flush_in = 1'b0; dma_ack = 1'b0;
      opcode = '0; func = '0;
      #1;
      check("rst_async_dma_req", 32'(use_t4 ? dma_req_b : dma_req), 32'd0);
      check("rst_async_sys_timeout", 32'(use_t4 ? sys_timeout_b : sys_timeout), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      check("reset_state", 32'(act), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      int pool[16] = '{0, 0, 35, 43, 4, 5, 2, 3, 8, 12, 13, 14, 10, 15, 32, 62};
      int hi, pulses;

      tbl[0]  = '{6'd0,  6'd32, {11'b10000100000, 4'd0},  1'b1, 1'b0, 1'b0}; // add
      tbl[1]  = '{6'd0,  6'd8,  {11'b10000000010, 4'd0},  1'b1, 1'b1, 1'b0}; // jr
      tbl[2]  = '{6'd35, 6'd0,  {11'b01101100000, 4'd2},  1'b1, 1'b0, 1'b0}; // lw
      tbl[3]  = '{6'd43, 6'd0,  {11'b00011000000, 4'd2},  1'b1, 1'b0, 1'b0}; // sw
      tbl[4]  = '{6'd4,  6'd0,  {11'b00000010000, 4'd6},  1'b1, 1'b1, 1'b0}; // beq
      tbl[5]  = '{6'd5,  6'd0,  {11'b00000001000, 4'd6},  1'b1, 1'b1, 1'b0}; // bne
      tbl[6]  = '{6'd2,  6'd0,  {11'b00000000100, 4'd0},  1'b1, 1'b1, 1'b0}; // j
      tbl[7]  = '{6'd3,  6'd0,  {11'b10000100001, 4'd0},  1'b1, 1'b0, 1'b0}; // jal
      tbl[8]  = '{6'd8,  6'd0,  {11'b00001100000, 4'd2},  1'b1, 1'b0, 1'b0}; // addi
      tbl[9]  = '{6'd12, 6'd0,  {11'b00001100000, 4'd0},  1'b1, 1'b0, 1'b0}; // andi
      tbl[10] = '{6'd13, 6'd0,  {11'b00001100000, 4'd1},  1'b1, 1'b0, 1'b0}; // ori
      tbl[11] = '{6'd14, 6'd0,  {11'b00001100000, 4'd13}, 1'b1, 1'b0, 1'b0}; // xori
      tbl[12] = '{6'd10, 6'd0,  {11'b00001100000, 4'd7},  1'b1, 1'b0, 1'b0}; // slti
      tbl[13] = '{6'd15, 6'd0,  {11'b00001100000, 4'd14}, 1'b1, 1'b0, 1'b0}; // lui
      tbl[14] = '{6'd32, 6'd0,  {11'b01101100000, 4'd2},  1'b1, 1'b0, 1'b0}; // lb
      tbl[15] = '{6'd9,  6'd0,  15'd0,                    1'b0, 1'b0, 1'b1}; // undefined

      do_reset();

      // Decode table, one instruction per cycle.
      for (int i = 0; i < 16; i++) begin
         instr_valid = 1'b1; opcode = tbl[i].op; func = tbl[i].fn;
         ex_stall = 1'b0; flush_in = 1'b0; dma_ack = 1'b0;
         #1;
         check($sformatf("tbl%0d_if_flush", i), 32'(if_flush), 32'(tbl[i].ifl));
         step($sformatf("tbl%0d", i), 1'b1, tbl[i].op, tbl[i].fn, 1'b0, 1'b0, 1'b0);
         check($sformatf("tbl%0d_ctrl", i), {16'd0, ctrl_valid, act_main[19:5]}, {16'd0, tbl[i].vld, tbl[i].ctrl});
         check($sformatf("tbl%0d_illegal", i), 32'(illegal), 32'(tbl[i].ill));
      end

      // sw, then addi held by ex_stall for 3 cycles.
      step("sw", 1'b1, 6'd43, 6'd0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step("addi_stall", 1'b1, 6'd8, 6'd0, 1'b1, 1'b0, 1'b0);
         check($sformatf("stall_hold%0d", k), {mem_write, reg_write, ctrl_valid}, 3'b101);
      end
      step("addi_go", 1'b1, 6'd8, 6'd0, 1'b0, 1'b0, 1'b0);
      check("addi_after_stall", {mem_write, reg_write, alu_op}, 6'b01_0010);

      // beq in the same cycle as flush_in.
      instr_valid = 1'b1; opcode = 6'd4; func = 6'd0; ex_stall = 1'b0; flush_in = 1'b1;
      #1;
      check("beq_flush_if_flush", 32'(if_flush), 32'd1);
      step("beq_flush", 1'b1, 6'd4, 6'd0, 1'b0, 1'b1, 1'b0);
      check("beq_flush_bubble", {ctrl_valid, branch}, 2'b00);

      // dma_ack in RUN is ignored; then syscall acknowledged in its 5th wait cycle.
      step("ack_in_run", 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
      step("syscall", 1'b1, 6'd62, 6'd0, 1'b0, 1'b0, 1'b0);
      hi = dma_req && stall_out ? 1 : 0;
      for (int k = 0; k < 4; k++) begin
         step("sys_wait", 1'b1, 6'd35, 6'd0, 1'b0, 1'b0, 1'b0);
         if (dma_req && stall_out) hi++;
      end
      check("sys_req_cycles", hi, 5);
      step("sys_ack", 1'b1, 6'd35, 6'd0, 1'b0, 1'b0, 1'b1);
      check("sys_after_ack", {dma_req, stall_out, ctrl_valid}, 3'b000);
      step("sys_resume_lw", 1'b1, 6'd35, 6'd0, 1'b0, 1'b0, 1'b0);
      check("sys_resume_lw_ctrl", {ctrl_valid, mem_read}, 2'b11);

      // Timeout on the SYS_TIMEOUT=4 instance, then a late ack is ignored.
      use_t4 = 1'b1;
      do_reset();
      step("t4_syscall", 1'b1, 6'd62, 6'd0, 1'b0, 1'b0, 1'b0);
      hi = dma_req_b ? 1 : 0;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         step("t4_wait", 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
         if (dma_req_b) hi++;
         if (sys_timeout_b) pulses++;
      end
      check("t4_req_cycles", hi, 4);
      check("t4_timeout_pulses", pulses, 1);
      step("t4_late_ack", 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
      check("t4_late_ack_ignored", {dma_req_b, stall_out_b, sys_timeout_b}, 3'b000);

      // Reset in the middle of a syscall wait.
      step("t4_syscall2", 1'b1, 6'd62, 6'd0, 1'b0, 1'b0, 1'b0);
      step("t4_wait2", 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
      check("t4_wait2_req", 32'(dma_req_b), 32'd1);
      #2;
      do_reset();

      // Illegal pulse, then sticky halt until reset.
      use_t4 = 1'b0;
      do_reset();
      step("ill_3d", 1'b1, 6'h3D, 6'd0, 1'b0, 1'b0, 1'b0);
      check("ill_pulse", {illegal, ctrl_valid}, 2'b10);
      step("ill_idle", 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
      check("ill_pulse_end", 32'(illegal), 32'd0);
      step("halt", 1'b1, 6'd63, 6'd0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         step("halted", 1'b1, 6'h3D, 6'd0, 1'b0, 1'b0, 1'b1);
         check($sformatf("halt_sticky%0d", k), {halted, stall_out, illegal, ctrl_valid}, 4'b1100);
      end
      do_reset();

      // Randomized stimulus on both instances against the model.
      for (int phase = 0; phase < 2; phase++) begin
         use_t4 = (phase == 1);
         do_reset();
         for (int n = 0; n < 600; n++) begin
            int r;
            logic [5:0] op, fn;
            r  = int'($urandom_range(0, 99));
            if (r < 2)       op = 6'd63;
            else if (r < 10) op = 6'($urandom);
            else             op = 6'(pool[$urandom_range(0, 15)]);
            fn = ($urandom_range(0, 1) == 0) ? 6'd8 : 6'($urandom);
            if ($urandom_range(0, 149) == 0) do_reset();
            else step("rand", ($urandom_range(0, 4) != 0), op, fn, ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
